dvp_capture_packer: RTL and testbench

DVP_CAPTURE_PACKER -- requirements
Module: dvp_capture_packer

---
 rtl/dvp_capture_packer.sv | 221 ++++++++++++++++++++++
 tb/tb_dvp_capture_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture_packer.sv
// dvp_capture_packer
//   Captures a DVP camera stream (already sampled into the clk domain),
//   converts or keeps pixels, decimates, packs them LSB-first into OUT_W-bit
//   words and queues the words in a small FIFO.
//
//   Ports
//     clk, rst_n          system clock, asynchronous active-low reset
//     cfg_start_i         capture enable
//     cfg_mode_i          00 RGB565->gray8, 01 raw byte, 10 RGB565 16-bit, 11 = 01
//     cfg_dec_i           decimation exponent n (keep 1 of 2^n per axis)
//     dvp_d_i/href/vsync  camera bus, sampled only when pclk_sync_i=1
//     pclk_sync_i         one-cycle strobe per PCLK rising edge
//     out_*               FIFO head: data, last-of-frame, valid; out_ready_i pops
//     ovf_o               sticky: a word was dropped because the FIFO was full
//     frame_cnt_o         completed frames (wrapping)
//
//   Assumes DVP_DATA_W >= 8 (low byte used), OUT_W multiple of 16,
//   FIFO_DEPTH a power of two >= 2.
module dvp_capture_packer #(
  parameter int DVP_DATA_W = 8,
  parameter int OUT_W      = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic [1:0]            cfg_dec_i,
  input  logic [DVP_DATA_W-1:0] dvp_d_i,
  input  logic                  dvp_href_i,
  input  logic                  dvp_vsync_i,
  input  logic                  pclk_sync_i,
  input  logic                  out_ready_i,
  output logic [OUT_W-1:0]      out_data_o,
  output logic                  out_last_o,
  output logic                  out_valid_o,
  output logic                  ovf_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int NB = OUT_W / 8;          // byte lanes per output word
  localparam int FW = $clog2(NB) + 1;     // fill counter, holds 0..NB
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;
  state_t state;

  // ---------------- sampled DVP edges ----------------
  logic href_q, vs_q;
  logic vs_fall, vs_rise, href_fall, byte_stb, cap_entry;
  logic [7:0] din;

  assign din       = dvp_d_i[7:0];
  assign vs_fall   = pclk_sync_i &  vs_q & ~dvp_vsync_i;
  assign vs_rise   = pclk_sync_i & ~vs_q &  dvp_vsync_i;
  assign href_fall = pclk_sync_i &  href_q & ~dvp_href_i;
  assign byte_stb  = (state == CAPTURE) & pclk_sync_i & dvp_href_i & ~vs_rise;
  assign cap_entry = (state == WAIT_VS) & cfg_start_i & vs_fall;

  // ---------------- pixel formation ----------------
  logic [1:0]       mode_q, dec_q;
  logic [CNT_W-1:0] col, row, dmask;
  logic             ph;          // 1 = high byte of a 16-bit pixel held
  logic [7:0]       hi_q;
  logic             two_byte, pix16, px_stb, keep;
  logic [15:0]      raw16, px, gsum;
  logic [7:0]       r8, g8, b8;

  assign two_byte = ~mode_q[0];               // modes 00 and 10
  assign pix16    = (mode_q == 2'b10);
  assign px_stb   = byte_stb & (~two_byte | ph);
  assign raw16    = {hi_q, din};

  assign r8   = {raw16[15:11], raw16[15:13]};
  assign g8   = {raw16[10:5],  raw16[10:9]};
  assign b8   = {raw16[4:0],   raw16[4:2]};
  // Max sum is 256*255, so 16 bits never overflow; truncation, no rounding.
  assign gsum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};

  always_comb begin
    px = {8'd0, din};
    if (pix16)         px = raw16;
    else if (two_byte) px = {8'd0, gsum[15:8]};
  end

  assign dmask = ~({CNT_W{1'b1}} << dec_q);
  assign keep  = px_stb & ((col & dmask) == '0) & ((row & dmask) == '0);

  // ---------------- packer ----------------
  logic [NB-1:0][7:0] pack, pack_nx;
  logic [FW-1:0]      fill, fill_nx;
  logic               word_done;

  always_comb begin
    pack_nx = pack;
    if (keep)
      for (int b = 0; b < NB; b++) begin
        if (FW'(b) == fill)                          pack_nx[b] = px[7:0];
        else if (pix16 && FW'(b) == fill + FW'(1))   pack_nx[b] = px[15:8];
      end
  end

  assign fill_nx   = fill + (pix16 ? FW'(2) : FW'(1));
  assign word_done = keep & (fill_nx == FW'(NB));

  // Completed / frame-end words are staged one cycle before the FIFO write.
  logic [OUT_W-1:0] wr_word;
  logic             wr_last, wr_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      href_q      <= 1'b0;
      vs_q        <= 1'b0;
      mode_q      <= 2'b00;
      dec_q       <= 2'b00;
      col         <= '0;
      row         <= '0;
      ph          <= 1'b0;
      hi_q        <= '0;
      pack        <= '0;
      fill        <= '0;
      wr_word     <= '0;
      wr_last     <= 1'b0;
      wr_vld      <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      wr_vld <= 1'b0;
      if (pclk_sync_i) begin
        href_q <= dvp_href_i;
        vs_q   <= dvp_vsync_i;
      end
      case (state)
        IDLE: if (cfg_start_i) state <= WAIT_VS;
        WAIT_VS: begin
          if (!cfg_start_i) state <= IDLE;
          else if (vs_fall) begin
            state  <= CAPTURE;
            mode_q <= cfg_mode_i;
            dec_q  <= cfg_dec_i;
            col    <= '0;
            row    <= '0;
            ph     <= 1'b0;
            pack   <= '0;
            fill   <= '0;
          end
        end
        CAPTURE: begin
          if (vs_rise) begin
            // Partial (zero-padded) or all-zero word closes the frame.
            wr_word     <= pack;
            wr_last     <= 1'b1;
            wr_vld      <= 1'b1;
            pack        <= '0;
            fill        <= '0;
            frame_cnt_o <= frame_cnt_o + 16'd1;
            state       <= cfg_start_i ? WAIT_VS : IDLE;
          end else if (href_fall) begin
            // Odd trailing byte of a 16-bit pixel is dropped via ph clear.
            col <= '0;
            row <= row + CNT_W'(1);
            ph  <= 1'b0;
          end else if (byte_stb) begin
            if (two_byte && !ph) begin
              hi_q <= din;
              ph   <= 1'b1;
            end else begin
              ph  <= 1'b0;
              col <= col + CNT_W'(1);
            end
            if (word_done) begin
              wr_word <= pack_nx;
              wr_last <= 1'b0;
              wr_vld  <= 1'b1;
              pack    <= '0;
              fill    <= '0;
            end else if (keep) begin
              pack <= pack_nx;
              fill <= fill_nx;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- output FIFO ----------------
  logic [OUT_W:0] mem [FIFO_DEPTH];   // {last, data}
  logic [AW:0]    wp, rp;
  logic           full, empty, pop, push_ok;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) & (wp[AW-1:0] == rp[AW-1:0]);
  assign pop     = ~empty & out_ready_i;
  assign push_ok = wr_vld & (~full | pop);   // push at full accepted if popping

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      ovf_o <= 1'b0;
    end else begin
      if (cap_entry) ovf_o <= 1'b0;
      if (push_ok) begin
        mem[wp[AW-1:0]] <= {wr_last, wr_word};
        wp              <= wp + 1'b1;
      end else if (wr_vld) begin
        ovf_o <= 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
  end

  assign out_valid_o = ~empty;
  assign out_data_o  = mem[rp[AW-1:0]][OUT_W-1:0];
  assign out_last_o  = mem[rp[AW-1:0]][OUT_W];

endmodule

// File: tb/tb_dvp_capture_packer.sv
// Directed bench for dvp_capture_packer (default parameters).
// Drives DVP samples as pclk_sync pulses, collects handshaken FIFO words in
// queues and compares against hand-computed words.
module tb_dvp_capture_packer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start_i;
  logic [1:0]   cfg_mode_i, cfg_dec_i;
  logic [7:0]   dvp_d_i;
  logic         dvp_href_i, dvp_vsync_i, pclk_sync_i, out_ready_i;
  logic [255:0] out_data_o;
  logic         out_last_o, out_valid_o, ovf_o;
  logic [15:0]  frame_cnt_o;

  always #5 clk = ~clk;

  dvp_capture_packer dut (
    .clk(clk), .rst_n(rst_n), .cfg_start_i(cfg_start_i), .cfg_mode_i(cfg_mode_i),
    .cfg_dec_i(cfg_dec_i), .dvp_d_i(dvp_d_i), .dvp_href_i(dvp_href_i),
    .dvp_vsync_i(dvp_vsync_i), .pclk_sync_i(pclk_sync_i), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .out_valid_o(out_valid_o),
    .ovf_o(ovf_o), .frame_cnt_o(frame_cnt_o)
  );

  int n_cmp = 0, n_bad = 0;
  logic [255:0] q_data[$];
  logic         q_last[$];

  // out_ready_i only changes shortly after posedge, so negedge is unambiguous.
  always @(negedge clk)
    if (rst_n && out_valid_o && out_ready_i) begin
      q_data.push_back(out_data_o);
      q_last.push_back(out_last_o);
    end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] qd(input int k);
    return (k < q_data.size()) ? q_data[k] : 'x;
  endfunction
  function automatic logic ql(input int k);
    return (k < q_last.size()) ? q_last[k] : 1'bx;
  endfunction

  task automatic pclk(input logic vs, input logic hr, input logic [7:0] d);
    @(negedge clk);
    dvp_vsync_i = vs; dvp_href_i = hr; dvp_d_i = d; pclk_sync_i = 1'b1;
    @(negedge clk);
    pclk_sync_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    pclk(1, 0, 0); pclk(1, 0, 0); pclk(0, 0, 0);
  endtask

  task automatic frame_end();
    pclk(0, 0, 0); pclk(1, 0, 0); idle(6);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #2 out_ready_i = v;
  endtask

  task automatic qclr();
    q_data.delete(); q_last.delete();
  endtask

  logic [255:0] exp_w;
  logic [15:0]  px16;
  int           k;

  initial begin
    rst_n = 0; cfg_start_i = 0; cfg_mode_i = 2'b01; cfg_dec_i = 0;
    dvp_d_i = 0; dvp_href_i = 0; dvp_vsync_i = 1; pclk_sync_i = 0; out_ready_i = 1;
    idle(3);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_last",  out_last_o, 0);
    chk("rst_data",  out_data_o, 0);
    chk("rst_ovf",   ovf_o, 0);
    chk("rst_fcnt",  frame_cnt_o, 0);
    rst_n = 1;
    idle(2);

    // ---- raw bytes, one full word then empty last word ----
    cfg_start_i = 1; cfg_mode_i = 2'b01; cfg_dec_i = 0;
    idle(2);
    frame_start();
    for (int i = 0; i < 31; i++) pclk(0, 1, 8'(i));
    pclk(0, 1, 8'd31);
    chk("lat_1clk", out_valid_o, 0);
    @(negedge clk);
    chk("lat_2clk", out_valid_o, 1);
    frame_end();
    for (int j = 0; j < 32; j++) exp_w[j*8 +: 8] = 8'(j);
    chk("raw_cnt",   q_data.size(), 2);
    chk("raw_w0",    qd(0), exp_w);
    chk("raw_l0",    ql(0), 0);
    chk("raw_w1",    qd(1), 0);
    chk("raw_l1",    ql(1), 1);
    chk("raw_fcnt",  frame_cnt_o, 1);
    qclr();

    // ---- gray conversion, odd trailing byte dropped ----
    cfg_mode_i = 2'b00;
    frame_start();
    pclk(0, 1, 8'hFF); pclk(0, 1, 8'hFF);     // white
    pclk(0, 1, 8'hF8); pclk(0, 1, 8'h00);     // red
    pclk(0, 1, 8'h07); pclk(0, 1, 8'hE0);     // green
    pclk(0, 1, 8'h00); pclk(0, 1, 8'h1F);     // blue
    pclk(0, 1, 8'hAB);                         // odd byte
    pclk(0, 0, 0);
    pclk(0, 1, 8'hFF); pclk(0, 1, 8'hFF);
    pclk(0, 0, 0);
    frame_end();
    exp_w = '0;
    exp_w[39:0] = 40'hFF_1C_95_4C_FF;
    chk("gray_cnt",  q_data.size(), 1);
    chk("gray_w0",   qd(0), exp_w);
    chk("gray_l0",   ql(0), 1);
    chk("gray_fcnt", frame_cnt_o, 2);
    qclr();

    // ---- RGB565 16-bit with decimation 1; mid-frame cfg change ignored ----
    cfg_mode_i = 2'b10; cfg_dec_i = 2'd1;
    frame_start();
    cfg_mode_i = 2'b01; cfg_dec_i = 2'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        px16 = 16'hA000 | 16'(r << 4) | 16'(c);
        pclk(0, 1, px16[15:8]); pclk(0, 1, px16[7:0]);
      end
      pclk(0, 0, 0);
    end
    frame_end();
    exp_w = '0; k = 0;
    for (int r = 0; r < 4; r += 2)
      for (int c = 0; c < 8; c += 2) begin
        exp_w[k*16 +: 16] = 16'hA000 | 16'(r << 4) | 16'(c);
        k++;
      end
    chk("dec_cnt",  q_data.size(), 1);
    chk("dec_w0",   qd(0), exp_w);
    chk("dec_l0",   ql(0), 1);
    chk("dec_fcnt", frame_cnt_o, 3);
    qclr();

    // ---- overflow with downstream stalled ----
    set_ready(0);
    cfg_mode_i = 2'b01; cfg_dec_i = 0;
    frame_start();
    for (int i = 0; i < 192; i++) pclk(0, 1, 8'(i));
    pclk(0, 0, 0);
    idle(3);
    for (int j = 0; j < 32; j++) exp_w[j*8 +: 8] = 8'(j);
    chk("ovf_valid", out_valid_o, 1);
    chk("ovf_flag",  ovf_o, 1);
    chk("ovf_head",  out_data_o, exp_w);
    idle(20);
    chk("ovf_stable", out_data_o, exp_w);
    frame_end();
    chk("ovf_fcnt", frame_cnt_o, 4);
    set_ready(1);
    idle(12);
    chk("ovf_cnt", q_data.size(), 4);
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 32; j++) exp_w[j*8 +: 8] = 8'(w*32 + j);
      chk($sformatf("ovf_w%0d", w), qd(w), exp_w);
      chk($sformatf("ovf_l%0d", w), ql(w), 0);
    end
    chk("ovf_sticky", ovf_o, 1);
    qclr();

    // ---- start dropped mid-frame: frame completes, then idle ----
    frame_start();
    chk("ovf_clr", ovf_o, 0);
    pclk(0, 1, 8'h55); pclk(0, 1, 8'h66);
    cfg_start_i = 0;
    pclk(0, 1, 8'h77); pclk(0, 1, 8'h88);
    pclk(0, 0, 0);
    frame_end();
    exp_w = '0; exp_w[31:0] = 32'h8877_6655;
    chk("stop_fcnt", frame_cnt_o, 5);
    chk("stop_cnt",  q_data.size(), 1);
    chk("stop_w0",   qd(0), exp_w);
    chk("stop_l0",   ql(0), 1);
    frame_start();
    pclk(0, 1, 8'h99); pclk(0, 0, 0);
    frame_end();
    chk("idle_cnt",  q_data.size(), 1);
    chk("idle_fcnt", frame_cnt_o, 5);
    qclr();

    // ---- reset mid-line ----
    cfg_start_i = 1;
    set_ready(0);
    idle(2);
    frame_start();
    pclk(0, 1, 8'h11); pclk(0, 0, 0);
    frame_end();
    chk("pre_valid", out_valid_o, 1);
    chk("pre_fcnt",  frame_cnt_o, 6);
    frame_start();
    pclk(0, 1, 8'h21); pclk(0, 1, 8'h22);
    #3 rst_n = 0;
    #1;
    chk("mrst_valid", out_valid_o, 0);
    chk("mrst_last",  out_last_o, 0);
    chk("mrst_data",  out_data_o, 0);
    chk("mrst_fcnt",  frame_cnt_o, 0);
    @(negedge clk); rst_n = 1;
    set_ready(1);
    pclk(0, 1, 8'h23); pclk(0, 1, 8'h24); pclk(0, 0, 0);
    pclk(1, 0, 0);
    idle(6);
    chk("post_fcnt", frame_cnt_o, 0);
    chk("post_cnt",  q_data.size(), 0);
    frame_start();
    pclk(0, 1, 8'h31); pclk(0, 1, 8'h32); pclk(0, 1, 8'h33); pclk(0, 1, 8'h34);
    pclk(0, 0, 0);
    frame_end();
    exp_w = '0; exp_w[31:0] = 32'h3433_3231;
    chk("clean_cnt",  q_data.size(), 1);
    chk("clean_w0",   qd(0), exp_w);
    chk("clean_l0",   ql(0), 1);
    chk("clean_fcnt", frame_cnt_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
